// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg
// Shared definitions for the two-digit multiplexed 7-segment scan controller:
// the scan state encoding, the lit patterns for each digit and the special
// digit codes (dash range and blank).
// Lit patterns are {dp,g,f,e,d,c,b,a} with 1 = segment lit; dp is never lit.
// -----------------------------------------------------------------------------
package dice_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHOW1  = 3'd1,
        ST_GAP1   = 3'd2,
        ST_SHOW10 = 3'd3,
        ST_GAP10  = 3'd4
    } scan_state_e;

    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    // Codes 10..14 all render as a dash; 15 renders nothing.
    localparam logic [3:0] DIGIT_DASH_LO = 4'd10;
    localparam logic [3:0] DIGIT_DASH_HI = 4'd14;
    localparam logic [3:0] DIGIT_BLANK   = 4'd15;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Bundles the controller's functional pins and its debug view.
//   master : drives ena, digit1, digit10, blank_lz, com_pol, seg_pol;
//            observes seg, com1, com10, com_oe and the debug signals.
//   slave  : the scan controller itself.
// There is no valid/ready handshake on this bus: every input is a level that
// the controller samples on each rising clock edge, and every output is a
// level valid for the whole cycle.
// Debug: state_dbg is the scan state register, dbg_digit1/dbg_digit10 are the
// digit values latched at the start of the current/last slot.
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if;
    import dice_pkg::*;

    logic        ena;
    logic [3:0]  digit1;
    logic [3:0]  digit10;
    logic        blank_lz;
    logic        com_pol;
    logic        seg_pol;
    logic [7:0]  seg;
    logic        com1;
    logic        com10;
    logic [1:0]  com_oe;
    scan_state_e state_dbg;
    logic [3:0]  dbg_digit1;
    logic [3:0]  dbg_digit10;

    modport master (
        output ena, digit1, digit10, blank_lz, com_pol, seg_pol,
        input  seg, com1, com10, com_oe, state_dbg, dbg_digit1, dbg_digit10
    );

    modport slave (
        input  ena, digit1, digit10, blank_lz, com_pol, seg_pol,
        output seg, com1, com10, com_oe, state_dbg, dbg_digit1, dbg_digit10
    );

endinterface

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational digit-code to lit-pattern decoder.
//   digit : 4-bit code (0-9 numeric, 10-14 dash, 15 blank)
//   lit   : 8-bit lit pattern {dp,g,f,e,d,c,b,a}, 1 = lit
// -----------------------------------------------------------------------------
module seg7_decode
    import dice_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] lit
);

    always_comb begin
        lit = SEG_DASH;
        case (digit)
            4'd0:        lit = SEG_0;
            4'd1:        lit = SEG_1;
            4'd2:        lit = SEG_2;
            4'd3:        lit = SEG_3;
            4'd4:        lit = SEG_4;
            4'd5:        lit = SEG_5;
            4'd6:        lit = SEG_6;
            4'd7:        lit = SEG_7;
            4'd8:        lit = SEG_8;
            4'd9:        lit = SEG_9;
            DIGIT_BLANK: lit = SEG_OFF;
            default:     lit = SEG_DASH;  // DIGIT_DASH_LO..DIGIT_DASH_HI
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexes a two-digit common-cathode/anode 7-segment display.
// Scan order: SHOW1 -> GAP1 -> SHOW10 -> GAP10 -> SHOW1 (GAPs skipped when
// GAP_CYCLES = 0). Each digit is latched when its SHOW slot starts.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : display_scan_ctrl_if.slave
//                inputs  ena, digit1, digit10, blank_lz, com_pol, seg_pol
//                outputs seg, com1, com10, com_oe, state_dbg, dbg_digit1/10
// Parameters:
//   DWELL_CYCLES : clocks per SHOW slot (>= 1)
//   GAP_CYCLES   : dead-time clocks between slots (>= 0)
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import dice_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Counter holds "clocks remaining after this one", so a slot of N clocks
    // is loaded with N-1 and the state advances when it reads 0.
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    scan_state_e   state;
    scan_state_e   nxt_state;
    logic [CW-1:0] cnt;
    logic [3:0]    d1_q;
    logic [3:0]    d10_q;
    logic [7:0]    lit_q;
    logic          act1_q;
    logic          act10_q;
    logic [1:0]    oe_q;

    logic [3:0]    dec_in;
    logic [7:0]    dec_lit;
    logic          blank10;

    // Next state of the scan sequence.
    always_comb begin
        nxt_state = state;
        if (!bus.ena) begin
            nxt_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   nxt_state = ST_SHOW1;
                ST_SHOW1:  if (cnt == '0) nxt_state = (GAP_CYCLES > 0) ? ST_GAP1 : ST_SHOW10;
                ST_GAP1:   if (cnt == '0) nxt_state = ST_SHOW10;
                ST_SHOW10: if (cnt == '0) nxt_state = (GAP_CYCLES > 0) ? ST_GAP10 : ST_SHOW1;
                ST_GAP10:  if (cnt == '0) nxt_state = ST_SHOW1;
                default:   nxt_state = ST_IDLE;
            endcase
        end
    end

    // The single decoder is pointed at whichever digit is about to be shown,
    // so its pattern can be captured into lit_q on the same edge as the state.
    assign dec_in  = (nxt_state == ST_SHOW10) ? bus.digit10 : bus.digit1;
    assign blank10 = bus.blank_lz && (bus.digit10 == 4'd0);

    seg7_decode u_decode (
        .digit (dec_in),
        .lit   (dec_lit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            d1_q    <= DIGIT_BLANK;
            d10_q   <= DIGIT_BLANK;
            lit_q   <= SEG_OFF;
            act1_q  <= 1'b0;
            act10_q <= 1'b0;
            oe_q    <= 2'b00;
        end else begin
            state <= nxt_state;
            oe_q  <= (nxt_state == ST_IDLE) ? 2'b00 : 2'b11;
            if (nxt_state != state) begin
                // Slot entry: load the timer and set up the slot's outputs.
                lit_q   <= SEG_OFF;
                act1_q  <= 1'b0;
                act10_q <= 1'b0;
                case (nxt_state)
                    ST_SHOW1: begin
                        cnt    <= DWELL_LD;
                        d1_q   <= bus.digit1;
                        lit_q  <= dec_lit;
                        act1_q <= 1'b1;
                    end
                    ST_SHOW10: begin
                        cnt     <= DWELL_LD;
                        d10_q   <= bus.digit10;
                        // Leading-zero blanking keeps the slot but darkens it.
                        lit_q   <= blank10 ? SEG_OFF : dec_lit;
                        act10_q <= !blank10;
                    end
                    ST_GAP1, ST_GAP10: cnt <= GAP_LD;
                    default:           cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Polarity is applied after the registers so it takes effect immediately.
    assign bus.seg         = bus.seg_pol ? lit_q : ~lit_q;
    assign bus.com1        = bus.com_pol ? act1_q : ~act1_q;
    assign bus.com10       = bus.com_pol ? act10_q : ~act10_q;
    assign bus.com_oe      = oe_q;
    assign bus.state_dbg   = state;
    assign bus.dbg_digit1  = d1_q;
    assign bus.dbg_digit10 = d10_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    localparam int DA = 4;  // dut_a: dwell 4, gap 2 (period 12)
    localparam int GA = 2;
    localparam int DB = 3;  // dut_b: dwell 3, no gap
    localparam int GB = 0;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ena      = 1'b0;
    logic [3:0] digit1   = 4'd0;
    logic [3:0] digit10  = 4'd0;
    logic       blank_lz = 1'b0;
    logic       com_pol  = 1'b1;
    logic       seg_pol  = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    display_scan_ctrl_if bus_a ();
    display_scan_ctrl_if bus_b ();

    assign bus_a.ena      = ena;
    assign bus_a.digit1   = digit1;
    assign bus_a.digit10  = digit10;
    assign bus_a.blank_lz = blank_lz;
    assign bus_a.com_pol  = com_pol;
    assign bus_a.seg_pol  = seg_pol;
    assign bus_b.ena      = ena;
    assign bus_b.digit1   = digit1;
    assign bus_b.digit10  = digit10;
    assign bus_b.blank_lz = blank_lz;
    assign bus_b.com_pol  = com_pol;
    assign bus_b.seg_pol  = seg_pol;

    display_scan_ctrl #(.DWELL_CYCLES(DA), .GAP_CYCLES(GA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    display_scan_ctrl #(.DWELL_CYCLES(DB), .GAP_CYCLES(GB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // ---------------- reference model ----------------
    // The scan is a fixed-period schedule: n counts clocks since the scan
    // (re)started, modulo 2*dwell + 2*gap. Digits are captured at the first
    // clock of their slot.
    typedef struct {
        bit         run;
        int         n;
        logic [3:0] c1;
        logic [3:0] c10;
        bit         blank;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.run   = 1'b0;
        m.n     = 0;
        m.c1    = 4'd15;
        m.c10   = 4'd15;
        m.blank = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int d, int g);
        int p;
        p = 2 * d + 2 * g;
        if (!ena) begin
            m.run = 1'b0;
        end else if (!m.run) begin
            m.run = 1'b1;
            m.n   = 0;
        end else begin
            m.n = (m.n + 1) % p;
        end
        if (m.run && m.n == 0) m.c1 = digit1;
        if (m.run && m.n == d + g) begin
            m.c10   = digit10;
            m.blank = blank_lz && (digit10 == 4'd0);
        end
        return m;
    endfunction

    function automatic logic [7:0] ref_dec(logic [3:0] v);
        case (v)
            4'd0:  return 8'h3F;
            4'd1:  return 8'h06;
            4'd2:  return 8'h5B;
            4'd3:  return 8'h4F;
            4'd4:  return 8'h66;
            4'd5:  return 8'h6D;
            4'd6:  return 8'h7D;
            4'd7:  return 8'h07;
            4'd8:  return 8'h7F;
            4'd9:  return 8'h6F;
            4'd15: return 8'h00;
            default: return 8'h40;
        endcase
    endfunction

    mdl_t ma = mdl_reset();
    mdl_t mb = mdl_reset();

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string who, input mdl_t m, input int d, input int g,
                             input logic [7:0] seg, input logic c1, input logic c10,
                             input logic [1:0] oe, input logic [3:0] l1, input logic [3:0] l10);
        logic [7:0] lit;
        logic       a1;
        logic       a10;
        lit = 8'h00;
        a1  = 1'b0;
        a10 = 1'b0;
        if (m.run) begin
            if (m.n < d) begin
                lit = ref_dec(m.c1);
                a1  = 1'b1;
            end else if (m.n >= d + g && m.n < 2 * d + g) begin
                lit = m.blank ? 8'h00 : ref_dec(m.c10);
                a10 = !m.blank;
            end
        end
        check_eq({who, "_seg"},   seg, seg_pol ? lit : ~lit);
        check_eq({who, "_com1"},  {7'd0, c1},  {7'd0, com_pol ? a1 : ~a1});
        check_eq({who, "_com10"}, {7'd0, c10}, {7'd0, com_pol ? a10 : ~a10});
        check_eq({who, "_oe"},    {6'd0, oe},  m.run ? 8'h03 : 8'h00);
        check_eq({who, "_lat1"},  {4'd0, l1},  {4'd0, m.c1});
        check_eq({who, "_lat10"}, {4'd0, l10}, {4'd0, m.c10});
        check_eq({who, "_both"},  {7'd0, (c1 == com_pol) && (c10 == com_pol)}, 8'h00);
    endtask

    always begin
        @(posedge clk);
        if (!rst_n) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_step(ma, DA, GA);
            mb = mdl_step(mb, DB, GB);
        end
        #1;
        check_dut("a", ma, DA, GA, bus_a.seg, bus_a.com1, bus_a.com10, bus_a.com_oe,
                  bus_a.dbg_digit1, bus_a.dbg_digit10);
        check_dut("b", mb, DB, GB, bus_b.seg, bus_b.com1, bus_b.com10, bus_b.com_oe,
                  bus_b.dbg_digit1, bus_b.dbg_digit10);
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Assert reset in the middle of a cycle and check it takes effect at once.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_a_seg",   bus_a.seg, seg_pol ? 8'h00 : 8'hFF);
        check_eq("rst_a_com1",  {7'd0, bus_a.com1},  {7'd0, ~com_pol});
        check_eq("rst_a_com10", {7'd0, bus_a.com10}, {7'd0, ~com_pol});
        check_eq("rst_a_oe",    {6'd0, bus_a.com_oe}, 8'h00);
        check_eq("rst_a_lat1",  {4'd0, bus_a.dbg_digit1}, 8'h0F);
        check_eq("rst_b_seg",   bus_b.seg, seg_pol ? 8'h00 : 8'hFF);
        check_eq("rst_b_oe",    {6'd0, bus_b.com_oe}, 8'h00);
        check_eq("rst_b_lat10", {4'd0, bus_b.dbg_digit10}, 8'h0F);
        cycles(2);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Basic scan: 7 / 3, active-high everything.
        digit1 = 4'd7; digit10 = 4'd3; ena = 1'b1;
        cycles(30);

        // Leading-zero blanking on and off; then 5 / 9.
        blank_lz = 1'b1; digit10 = 4'd0; digit1 = 4'd4;
        cycles(30);
        blank_lz = 1'b0;
        cycles(24);
        digit1 = 4'd5; digit10 = 4'd9;
        cycles(24);

        // Inverted polarities.
        seg_pol = 1'b0; com_pol = 1'b0; digit1 = 4'd8;
        cycles(24);
        seg_pol = 1'b1; com_pol = 1'b1;

        // Mid-slot digit change, then a dash code.
        digit1 = 4'd2; ena = 1'b0;
        cycles(2);
        ena = 1'b1;
        cycles(2);
        digit1 = 4'd6;
        cycles(14);
        digit1 = 4'd12;
        cycles(14);

        // Reset in the middle of dut_a's SHOW10, later drop ena.
        ena = 1'b0;
        cycles(1);
        ena = 1'b1;
        cycles(7);
        pulse_reset();
        cycles(10);
        ena = 1'b0;
        cycles(3);
        ena = 1'b1;

        // Randomized traffic.
        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) digit1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                digit10 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 9) == 0) seg_pol = ~seg_pol;
            if ($urandom_range(0, 9) == 0) com_pol = ~com_pol;
            if ($urandom_range(0, 39) == 0) ena = ~ena;
            else if (!ena && $urandom_range(0, 3) == 0) ena = 1'b1;
            if ($urandom_range(0, 149) == 0) pulse_reset();
        end

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000: clocks each digit stays lit per scan slot; legal range >= 1.
REQ-002 Parameter GAP_CYCLES, default 16: dead-time clocks, both commons inactive, between slots; 0 is legal.
REQ-003 clk  input  1  single clock; one clock, all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  design selected; low forces IDLE.
REQ-006 digit1  input  4  units value; 0-9 numeric, 15 blank, 10-14 dash.
REQ-007 digit10  input  4  tens value; same coding as digit1.
REQ-008 blank_lz  input  1  high: suppress tens digit when it is 0.
REQ-009 com_pol  input  1  common active level (1 = active high).
REQ-010 seg_pol  input  1  segment lit level (1 = active high).
REQ-011 seg  output  8  segment bus {dp,g,f,e,d,c,b,a}, dp always unlit.
REQ-012 com1  output  1  units common.
REQ-013 com10  output  1  tens common.
REQ-014 com_oe  output  2  output enables for {com10,com1}.

Function
REQ-015 States: IDLE, SHOW1, GAP1, SHOW10, GAP10; scan order SHOW1->GAP1->SHOW10->GAP10->SHOW1.
REQ-016 IDLE->SHOW1 on the first clock with ena high; any state->IDLE on the clock after ena is sampled low.
REQ-017 A down-counter of width clog2(max(DWELL_CYCLES,GAP_CYCLES)+1) is loaded on each state entry; the state advances on the clock the counter reaches 0.
REQ-018 SHOW1 and SHOW10 each last exactly DWELL_CYCLES clocks; GAP1 and GAP10 each last exactly GAP_CYCLES clocks.
REQ-019 When GAP_CYCLES = 0, the GAP states are skipped, giving SHOW1->SHOW10 directly.
REQ-020 digit1/digit10 are latched only on entry to the matching SHOW state; input changes mid-slot do not appear until the next slot.
REQ-021 Decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, 10-14=40 (dash), 15=00, all as lit-pattern hex.
REQ-022 During SHOW1 com1 is active; during SHOW10 com10 is active; otherwise both commons are inactive; both commons are never active in the same cycle.
REQ-023 In SHOW10, when blank_lz=1 and the latched digit10=0, com10 stays inactive and the lit pattern is 00; slot timing is unchanged.
REQ-024 The lit pattern is 00 in IDLE and GAP states.
REQ-025 Lit pattern and common activity are registered; outputs are those registers combinationally XORed with polarity (seg = lit when seg_pol=1, else ~lit; com = act when com_pol=1, else ~act).
REQ-026 com_oe = 2'b11 whenever ena is high, and 2'b00 in IDLE.
REQ-027 A polarity change is reflected on outputs in the same cycle; the state machine is unaffected.

Reset
REQ-028 rst_n low asynchronously forces IDLE, counter 0, latched digits 15, lit 00, commons inactive, com_oe 00.
REQ-029 Reset assertion mid-slot takes effect immediately, with no partial-slot completion; after release the scan restarts at SHOW1.

Structure
REQ-030 The state enum, the 7-segment pattern constants and the dash/blank codes reside in shared package dice_pkg.
REQ-031 Decoding is done in sub-module seg7_decode (4-bit in, 8-bit lit pattern out, combinational), instantiated once and shared between slots.

Verification
REQ-032 Scenario 1: DWELL=4, GAP=2, digit1=7, digit10=3, pols=1 -> com1 high for 4 clk with seg=07, 2 clk idle, com10 high for 4 clk with seg=4F; period 12 clk.
REQ-033 Scenario 2: GAP=0, digit1=5, digit10=9 -> SHOW1 and SHOW10 are adjacent; commons are never simultaneously active.
REQ-034 Scenario 3: blank_lz=1, digit10=0, digit1=4 -> com10 never active and seg=00 in SHOW10; with blank_lz=0, seg=3F in SHOW10.
REQ-035 Scenario 4: seg_pol=0, com_pol=0, digit1=8 -> seg=80 and com1=0 during SHOW1; in GAP, seg=FF and both commons 1.
REQ-036 Scenario 5: digit1 changes 2->6 mid-SHOW1 -> seg stays 5B to the slot end; the next SHOW1 shows 7D. digit1=12 -> seg=40.
REQ-037 Scenario 6: rst_n pulsed low mid-SHOW10 and ena dropped later -> outputs reach reset values asynchronously; SHOW1 follows release; ena low -> IDLE and com_oe=00 next clock.
